// File: rtl/ysyx_25030081_imm_enc.sv
// ysyx_25030081_imm_enc: packs an immediate plus register/funct/opcode fields into an RV32 instruction word.
//   Inverse of the core's immediate extractor, used by the self-test injector and trace replay.
//   Two-stage valid/ready pipeline: stage 1 registers the request and flags unencodable
//   immediates or illegal formats, stage 2 assembles the instruction word.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    request handshake
//   in_fmt               000 I, 001 U, 010 S, 011 B, 100 J, others illegal
//   in_imm               32-bit immediate (byte offset for B/J)
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3   instruction fields
//   out_valid/out_ready  result handshake
//   out_inst             encoded instruction (zero when out_err)
//   out_err              immediate not encodable or format illegal
//   err_cnt              saturating count of errored results handed off
module ysyx_25030081_imm_enc #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [31:0]          in_imm,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_U = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
    logic        s1Valid, s2Valid, s1Adv, s2Adv, s1Err, immErr;
    logic        fits12, fits13, fits21;
    logic [2:0]  s1Fmt, s1Funct3;
    logic [31:0] s1Imm, instNext;
    logic [6:0]  s1Opcode;
    logic [4:0]  s1Rd, s1Rs1, s1Rs2;

    assign s2Adv     = !s2Valid || out_ready;
    assign s1Adv     = !s1Valid || s2Adv;
    assign in_ready  = s1Adv;
    assign out_valid = s2Valid;

    // imm[31:k] all equal means imm fits a (k+1)-bit signed field
    assign fits12 = &in_imm[31:11] || ~|in_imm[31:11];
    assign fits13 = &in_imm[31:12] || ~|in_imm[31:12];
    assign fits21 = &in_imm[31:20] || ~|in_imm[31:20];

    always_comb begin
        immErr = (in_fmt == FMT_I || in_fmt == FMT_S) ? !fits12 :
                 (in_fmt == FMT_U) ? |in_imm[11:0] :
                 (in_fmt == FMT_B) ? in_imm[0] || !fits13 :
                 (in_fmt == FMT_J) ? in_imm[0] || !fits21 : 1'b1;
    end

    always_comb begin
        instNext = s1Err ? 32'h0 :
                   (s1Fmt == FMT_I) ? {s1Imm[11:0], s1Rs1, s1Funct3, s1Rd, s1Opcode} :
                   (s1Fmt == FMT_U) ? {s1Imm[31:12], s1Rd, s1Opcode} :
                   (s1Fmt == FMT_S) ? {s1Imm[11:5], s1Rs2, s1Rs1, s1Funct3, s1Imm[4:0], s1Opcode} :
                   (s1Fmt == FMT_B) ? {s1Imm[12], s1Imm[10:5], s1Rs2, s1Rs1, s1Funct3, s1Imm[4:1], s1Imm[11], s1Opcode} :
                   {s1Imm[20], s1Imm[10:1], s1Imm[11], s1Imm[19:12], s1Rd, s1Opcode};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid  <= 1'b0;
            s1Err    <= 1'b0;
            s1Fmt    <= '0;
            s1Imm    <= '0;
            s1Opcode <= '0;
            s1Rd     <= '0;
            s1Rs1    <= '0;
            s1Rs2    <= '0;
            s1Funct3 <= '0;
        end else if (s1Adv) begin
            s1Valid <= in_valid;
            if (in_valid) begin
                s1Err    <= immErr;
                s1Fmt    <= in_fmt;
                s1Imm    <= in_imm;
                s1Opcode <= in_opcode;
                s1Rd     <= in_rd;
                s1Rs1    <= in_rs1;
                s1Rs2    <= in_rs2;
                s1Funct3 <= in_funct3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid  <= 1'b0;
            out_inst <= '0;
            out_err  <= 1'b0;
        end else if (s2Adv) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
                out_inst <= instNext;
                out_err  <= s1Err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (out_valid && out_ready && out_err && !(&err_cnt))
            err_cnt <= err_cnt + 1'b1;
    end
endmodule

// File: tb/tb_ysyx_25030081_imm_enc.sv
// tb_ysyx_25030081_imm_enc: self-checking bench for the immediate encoder.
module tb_ysyx_25030081_imm_enc;
    typedef struct packed {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        err;
    } ExpEntry;

    logic        clk, rstN, inValid, inReady, outValid, outReady, outErr;
    logic [2:0]  inFmt, inFunct3;
    logic [31:0] inImm, outInst;
    logic [6:0]  inOpcode;
    logic [4:0]  inRd, inRs1, inRs2;
    logic [7:0]  errCnt;

    int checks = 0;
    int errors = 0;
    ExpEntry q[$];
    logic [7:0]  expErrCnt;
    logic        heldValid, heldErr;
    logic [31:0] heldInst;

    ysyx_25030081_imm_enc #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rstN),
        .in_valid(inValid), .in_ready(inReady),
        .in_fmt(inFmt), .in_imm(inImm), .in_opcode(inOpcode),
        .in_rd(inRd), .in_rs1(inRs1), .in_rs2(inRs2), .in_funct3(inFunct3),
        .out_valid(outValid), .out_ready(outReady),
        .out_inst(outInst), .out_err(outErr), .err_cnt(errCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Encoder model from the architectural field layout, using plain range arithmetic.
    function automatic ExpEntry refEnc(input logic [2:0] f, input logic [31:0] imm, input logic [6:0] op,
                                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] f3);
        int si;
        logic ok;
        logic [31:0] w;
        ExpEntry e;
        si = imm;
        w = 32'(op);
        ok = 1'b0;
        case (f)
            3'd0: begin
                ok = si >= -2048 && si <= 2047;
                w |= ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
            end
            3'd1: begin
                ok = (imm & 32'hFFF) == 0;
                w |= (imm & 32'hFFFFF000) | (32'(rd) << 7);
            end
            3'd2: begin
                ok = si >= -2048 && si <= 2047;
                w |= (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                   | (32'(f3) << 12) | ((imm & 32'h1F) << 7);
            end
            3'd3: begin
                ok = si >= -4096 && si <= 4094 && (si % 2 == 0);
                w |= (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
                   | (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            end
            3'd4: begin
                ok = si >= -1048576 && si <= 1048574 && (si % 2 == 0);
                w |= (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                   | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7);
            end
            default: ok = 1'b0;
        endcase
        e.fmt = f;
        e.imm = imm;
        e.err = !ok;
        e.inst = ok ? w : 32'h0;
        return e;
    endfunction

    // The core's immediate extractor, used for the round-trip property.
    function automatic logic [31:0] extract(input logic [2:0] f, input logic [31:0] inst);
        logic signed [31:0] s;
        logic [31:0] sx20, sx25, sx31;
        s = inst;
        sx20 = s >>> 20;
        sx25 = s >>> 25;
        sx31 = s >>> 31;
        case (f)
            3'd0: return sx20;
            3'd1: return inst & 32'hFFFFF000;
            3'd2: return (sx25 << 5) | ((inst >> 7) & 32'h1F);
            3'd3: return (sx31 << 12) | (((inst >> 7) & 32'h1) << 11) | (((inst >> 25) & 32'h3F) << 5)
                       | (((inst >> 8) & 32'hF) << 1);
            default: return (sx31 << 20) | (inst & 32'h000FF000) | (((inst >> 20) & 32'h1) << 11)
                          | (((inst >> 21) & 32'h3FF) << 1);
        endcase
    endfunction

    function automatic logic [31:0] randImm();
        logic [31:0] b[10];
        b = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, 32'd4094, -32'sd4096, 32'd4095,
              32'd1048574, -32'sd1048576, 32'd1048576};
        case ($urandom % 5)
            0: return $urandom;
            1: return 32'($urandom_range(0, 8191)) - 32'd4096;
            2: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
            3: return $urandom & 32'hFFFFF000;
            default: return b[$urandom % 10];
        endcase
    endfunction

    task automatic randFields();
        inFmt = ($urandom % 8 < 6) ? 3'($urandom % 5) : 3'($urandom_range(5, 7));
        inImm = randImm();
        inOpcode = 7'($urandom);
        inRd = 5'($urandom);
        inRs1 = 5'($urandom);
        inRs2 = 5'($urandom);
        inFunct3 = 3'($urandom);
    endtask

    task automatic runOne(input string tag, input logic [2:0] f, input logic [31:0] imm, input logic [6:0] op,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [2:0] f3, input logic [31:0] expInst, input logic expErr);
        inValid = 1'b1;
        inFmt = f;
        inImm = imm;
        inOpcode = op;
        inRd = rd;
        inRs1 = rs1;
        inRs2 = rs2;
        inFunct3 = f3;
        @(posedge clk); #1;
        inValid = 1'b0;
        check({tag, "_valid_early"}, 32'(outValid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(outValid), 32'd1);
        check({tag, "_inst"}, outInst, expInst);
        check({tag, "_err"}, 32'(outErr), 32'(expErr));
        if (!expErr) check({tag, "_roundtrip"}, extract(f, outInst), imm);
        @(posedge clk); #1;
    endtask

    task automatic monitorStep();
        ExpEntry e;
        check("err_cnt_track", 32'(errCnt), 32'(expErrCnt));
        if (heldValid) begin
            check("hold_valid", 32'(outValid), 32'd1);
            check("hold_inst", outInst, heldInst);
            check("hold_err", 32'(outErr), 32'(heldErr));
        end
        if (outValid && outReady) begin
            if (q.size() == 0) check("spurious_out", 32'(outValid), 32'd0);
            else begin
                e = q.pop_front();
                check("rand_inst", outInst, e.inst);
                check("rand_err", 32'(outErr), 32'(e.err));
                if (!e.err) check("rand_roundtrip", extract(e.fmt, outInst), e.imm);
                if (e.err && expErrCnt != 8'hFF) expErrCnt++;
            end
        end
        heldValid = outValid && !outReady;
        heldInst = outInst;
        heldErr = outErr;
    endtask

    initial begin
        ExpEntry bp[4];
        int k, n, firstC, lastC;
        logic acc, pend;
        rstN = 1'b0;
        inValid = 1'b0;
        outReady = 1'b1;
        inFmt = '0; inImm = '0; inOpcode = '0; inRd = '0; inRs1 = '0; inRs2 = '0; inFunct3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(outValid), 32'd0);
        check("rst_inst", outInst, 32'd0);
        check("rst_err", 32'(outErr), 32'd0);
        check("rst_cnt", 32'(errCnt), 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        check("rst_in_ready", 32'(inReady), 32'd1);

        runOne("I",  3'd0, 32'hFFFFFFFF, 7'h13, 5'd1, 5'd0, 5'h1F, 3'd0, 32'hFFF00093, 1'b0);
        runOne("U",  3'd1, 32'h12345000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h123452B7, 1'b0);
        runOne("S",  3'd2, 32'd8,        7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 32'h0021A423, 1'b0);
        runOne("B",  3'd3, 32'hFFFFFFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFE000EE3, 1'b0);
        runOne("J",  3'd4, 32'h00000800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h001000EF, 1'b0);
        check("cnt_after_ok", 32'(errCnt), 32'd0);
        runOne("Ierr", 3'd0, 32'd2048, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0, 1'b1);
        check("cnt_one", 32'(errCnt), 32'd1);
        runOne("Berr", 3'd3, 32'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 1'b1);
        runOne("Uerr", 3'd1, 32'd1, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0, 1'b1);
        runOne("Ferr", 3'd6, 32'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0, 1'b1);
        check("cnt_four", 32'(errCnt), 32'd4);

        // backpressure: four requests into a stalled output
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) bp[i] = refEnc(3'd0, 32'(i + 1), 7'h13, 5'(i + 1), 5'd2, 5'd0, 3'd0);
        k = 0;
        for (int c = 0; c < 6; c++) begin
            inValid = k < 4;
            inFmt = 3'd0; inImm = 32'(k + 1); inOpcode = 7'h13; inRd = 5'(k + 1); inRs1 = 5'd2; inFunct3 = 3'd0;
            @(negedge clk);
            acc = inValid && inReady;
            @(posedge clk); #1;
            if (acc) k++;
        end
        check("bp_accepts", 32'(k), 32'd2);
        check("bp_in_ready", 32'(inReady), 32'd0);
        check("bp_valid", 32'(outValid), 32'd1);
        check("bp_hold_inst", outInst, bp[0].inst);
        outReady = 1'b1;
        n = 0;
        firstC = -1;
        lastC = -1;
        for (int c = 0; c < 10; c++) begin
            inValid = k < 4;
            inFmt = 3'd0; inImm = 32'(k + 1); inOpcode = 7'h13; inRd = 5'(k + 1); inRs1 = 5'd2; inFunct3 = 3'd0;
            @(negedge clk);
            acc = inValid && inReady;
            if (outValid && outReady) begin
                if (n < 4) check("bp_order", outInst, bp[n].inst);
                else check("bp_extra", 32'(outValid), 32'd0);
                if (firstC < 0) firstC = c;
                lastC = c;
                n++;
            end
            @(posedge clk); #1;
            if (acc) k++;
        end
        inValid = 1'b0;
        check("bp_count", 32'(n), 32'd4);
        check("bp_rate", 32'(lastC - firstC), 32'd3);

        // randomized stream against the model
        expErrCnt = errCnt == 8'd4 ? 8'd4 : 8'd4;
        heldValid = 1'b0;
        pend = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!pend) begin
                inValid = ($urandom % 4) != 0;
                randFields();
            end
            outReady = ($urandom % 4) != 0;
            @(negedge clk);
            check("rand_in_ready", 32'(inReady), 32'((q.size() < 2) || outReady));
            monitorStep();
            if (inValid && inReady) q.push_back(refEnc(inFmt, inImm, inOpcode, inRd, inRs1, inRs2, inFunct3));
            pend = inValid && !inReady;
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        outReady = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            monitorStep();
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
        check("drain_cnt", 32'(errCnt), 32'(expErrCnt));

        // saturation
        inValid = 1'b1;
        inFmt = 3'd6;
        repeat (300) @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("cnt_saturated", 32'(errCnt), 32'd255);

        // async reset with both stages full
        outReady = 1'b0;
        inValid = 1'b1;
        inFmt = 3'd0;
        inImm = 32'd5;
        repeat (2) @(posedge clk);
        #1;
        check("full_valid", 32'(outValid), 32'd1);
        check("full_in_ready", 32'(inReady), 32'd0);
        #2;
        rstN = 1'b0;
        #1;
        check("arst_valid", 32'(outValid), 32'd0);
        check("arst_cnt", 32'(errCnt), 32'd0);
        check("arst_inst", outInst, 32'd0);
        inValid = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        outReady = 1'b1;
        check("arst_in_ready", 32'(inReady), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("arst_no_stale", 32'(outValid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
